sobel_window_gen: RTL and testbench

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

---
 rtl/sobel_window_gen.sv | 138 +++++++++++++
 tb/tb_sobel_window_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// 3x3 raster window generator for a Sobel stage: two line RAMs plus a register window.
// Define SOBEL_WIN_BORDER_ZERO_EN for zero border taps; by default, border taps replicate the nearest edge pixel.
module sobel_window_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_pix,
  input  logic        sof,
  output logic        out_valid,
  output logic [71:0] out_win,
  output logic [12:0] out_col,
  output logic [12:0] out_row
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  typedef struct packed {
    logic [7:0] top;
    logic [7:0] mid;
    logic [7:0] bot;
  } column_t;

  state_t        state_q;
  logic [12:0]   col_q, row_q;
  logic          valid_q;
  logic [71:0]   win_q;
  logic [12:0]   outCol_q, outRow_q;

  logic [7:0]    lineA_q [IMG_W];
  logic [7:0]    lineB_q [IMG_W];
  column_t       colNear_q, colFar_q;

  logic          accept, startFrame, emit, lastCol, lastRow;
  logic [12:0]   pc, pr, col_d, row_d;
  logic [AW-1:0] addr;
  logic [7:0]    rdA, rdB, topBorder;
  column_t       newCol, leftCol, leftBorder;
  logic [71:0]   win_d;

  // lineA holds the previous row and lineB the row before it, both indexed by column.
  always_comb begin
    startFrame = in_valid && sof;
    accept     = in_valid && ((state_q != IDLE) || sof);
    pc         = startFrame ? 13'd0 : col_q;
    pr         = startFrame ? 13'd0 : row_q;
    lastCol    = (pc == 13'(IMG_W - 1));
    lastRow    = (pr == 13'(IMG_H - 1));
    addr       = pc[AW-1:0];
    rdA        = lineA_q[addr];
    rdB        = lineB_q[addr];

`ifdef SOBEL_WIN_BORDER_ZERO_EN
    topBorder  = 8'h00;
    leftBorder = '0;
`else
    topBorder  = rdA;
    leftBorder = colNear_q;
`endif

    newCol.bot = in_pix;
    newCol.mid = rdA;
    newCol.top = (pr == 13'd1) ? topBorder : rdB;
    leftCol    = (pc == 13'd1) ? leftBorder : colFar_q;

    win_d = {newCol.bot, colNear_q.bot, leftCol.bot,
             newCol.mid, colNear_q.mid, leftCol.mid,
             newCol.top, colNear_q.top, leftCol.top};

    emit = accept && !startFrame && (state_q == RUN) && (pc != 13'd0);

    col_d = pc + 13'd1;
    row_d = pr;
    if (lastCol) begin
      col_d = 13'd0;
      row_d = lastRow ? 13'd0 : pr + 13'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      valid_q  <= 1'b0;
      win_q    <= '0;
      outCol_q <= '0;
      outRow_q <= '0;
    end else begin
      valid_q <= emit;
      if (emit) begin
        win_q    <= win_d;
        outCol_q <= pc - 13'd1;
        outRow_q <= pr - 13'd1;
      end
      if (accept) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      unique case (state_q)
        IDLE: if (startFrame) state_q <= lastCol ? RUN : FILL;
        FILL: begin
          if (startFrame)
            state_q <= lastCol ? RUN : FILL;
          else if (accept && lastCol)
            state_q <= RUN;
        end
        RUN: begin
          if (startFrame)
            state_q <= lastCol ? RUN : FILL;
          else if (accept && lastCol && lastRow)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line RAMs and window columns carry no reset; stale contents are never emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lineA_q[addr] <= in_pix;
      lineB_q[addr] <= rdA;
      colFar_q      <= colNear_q;
      colNear_q     <= newCol;
    end
  end

  assign out_valid = valid_q;
  assign out_win   = win_q;
  assign out_col   = outCol_q;
  assign out_row   = outRow_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 4x3 image; SOBEL_WIN_BORDER_ZERO_EN selects the border model.
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_pix = 8'h00;
  logic        sof = 1'b0;
  logic        out_valid;
  logic [71:0] out_win;
  logic [12:0] out_col, out_row;

  typedef struct packed {
    logic [12:0] row;
    logic [12:0] col;
    logic [71:0] win;
  } expWin_t;

  expWin_t     expQ[$];
  logic [7:0]  img [H][W];
  int          testsRun = 0;
  int          failCount = 0;
  bit          modelActive = 1'b0;
  int          mRow = 0, mCol = 0;
  bit          checkLiterals = 1'b0;
  logic [71:0] lastWin = '0;
  logic [12:0] lastCol = '0, lastRow = '0;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_pix    (in_pix),
    .sof       (sof),
    .out_valid (out_valid),
    .out_win   (out_win),
    .out_col   (out_col),
    .out_row   (out_row)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [97:0] observed, input logic [97:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] pixVal(input int f, input int r, input int c);
    return 8'(64 * f + 16 * r + c);
  endfunction

  function automatic logic [7:0] tap(input int r, input int c);
`ifdef SOBEL_WIN_BORDER_ZERO_EN
    if (r < 0 || c < 0) return 8'h00;
`else
    if (r < 0) r = 0;
    if (c < 0) c = 0;
`endif
    return img[r][c];
  endfunction

  function automatic logic [71:0] modelWin(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++)
      w[8*k +: 8] = tap(r - 1 + k / 3, c - 1 + k % 3);
    return w;
  endfunction

  // One clock of stimulus; inputs change just after a falling edge, outputs are read on the next one.
  task automatic applyStimulus(input bit v, input bit s, input logic [7:0] pix);
    bit hasWin;
    int pr, pc;
    expWin_t e;
    logic [71:0] lit;
    in_valid = v;
    sof      = s;
    in_pix   = pix;
    hasWin   = 1'b0;
    if (v && (modelActive || s)) begin
      pr = s ? 0 : mRow;
      pc = s ? 0 : mCol;
      img[pr][pc] = pix;
      if (pr >= 1 && pc >= 1) begin
        hasWin = 1'b1;
        expQ.push_back({13'(pr - 1), 13'(pc - 1), modelWin(pr - 1, pc - 1)});
      end
      modelActive = 1'b1;
      mRow = pr;
      mCol = pc + 1;
      if (pc == W - 1) begin
        mCol = 0;
        mRow = pr + 1;
        if (pr == H - 1) begin
          mRow = 0;
          modelActive = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    sof      = 1'b0;
    checkOutput("outValid", 98'(out_valid), 98'(hasWin));
    if (out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWin", 98'(1), 98'(0));
      end else begin
        e = expQ.pop_front();
        checkOutput("winRowCol", 98'({out_row, out_col}), 98'({e.row, e.col}));
        checkOutput("winData", 98'(out_win), 98'(e.win));
        if (checkLiterals && e.row == 13'd1 && e.col == 13'd1)
          checkOutput("interiorLit", 98'(out_win), 98'(72'h22_21_20_12_11_10_02_01_00));
        if (checkLiterals && e.row == 13'd0 && e.col == 13'd0) begin
`ifdef SOBEL_WIN_BORDER_ZERO_EN
          lit = 72'h11_10_00_01_00_00_00_00_00;
`else
          lit = 72'h11_10_10_01_00_00_01_00_00;
`endif
          checkOutput("cornerLit", 98'(out_win), 98'(lit));
        end
        lastWin = e.win;
        lastCol = e.col;
        lastRow = e.row;
      end
    end else begin
      checkOutput("holdOutputs", 98'({out_row, out_col, out_win}), 98'({lastRow, lastCol, lastWin}));
    end
  endtask

  // Sends linear pixel indices first..last of frame f; index 0 carries sof.
  task automatic sendPixels(input int f, input int first, input int last, input bit stall);
    for (int i = first; i <= last; i++) begin
      if (stall)
        while ($urandom_range(1, 0) == 1) applyStimulus(1'b0, 1'b0, 8'($urandom_range(255, 0)));
      applyStimulus(1'b1, i == 0, pixVal(f, i / W, i % W));
    end
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    checkOutput("resetValid", 98'(out_valid), 98'(0));
    checkOutput("resetOutputs", 98'({out_row, out_col, out_win}), 98'(0));
    modelActive = 1'b0;
    mRow = 0;
    mCol = 0;
    lastWin = '0;
    lastCol = '0;
    lastRow = '0;
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("resetValid", 98'(out_valid), 98'(0));
    checkOutput("resetWin", 98'(out_win), 98'(0));
    checkOutput("resetColRow", 98'({out_row, out_col}), 98'(0));
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b1, 1'b0, 8'h55);
    applyStimulus(1'b1, 1'b0, 8'h66);

    checkLiterals = 1'b1;
    sendPixels(0, 0, W * H - 1, 1'b0);
    checkLiterals = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);

    sendPixels(1, 0, W * H - 1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00);

    sendPixels(2, 0, 2 * W, 1'b0);
    sendPixels(3, 0, W * H - 1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00);

    sendPixels(1, 0, W + 1, 1'b0);
    pulseReset();
    applyStimulus(1'b1, 1'b0, pixVal(1, 1, 2));
    applyStimulus(1'b1, 1'b0, pixVal(1, 1, 3));
    applyStimulus(1'b1, 1'b0, pixVal(1, 2, 0));
    sendPixels(2, 0, W * H - 1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);

    checkOutput("queueEmpty", 98'(expQ.size()), 98'(0));
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
